// File: rtl/pattern_seq_pkg.sv
// ---------------------------------------------------------------------------
// pattern_seq_pkg
// Shared definitions for the pattern sequencer slice: memory geometry,
// derived widths and the controller state encoding.
//   ADDR_W : word-address width (16-word pattern memory)
//   DATA_W : memory word width; the shifter only supports 8-bit words
//   CNT_W  : width of word counts, wide enough to hold a full pass of 16
//   BIT_W  : width of the bit index inside one word
// ---------------------------------------------------------------------------
package pattern_seq_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int BIT_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// pattern_sequencer_if
// Bundles the run-control, pattern-memory and serial-output signals of the
// pattern sequencer.
//   start, base_addr, num_words, loop, stop : run control into the sequencer
//   mem_rd_en, mem_addr                     : read request to pattern memory
//   mem_rdata                               : read data, one cycle after request
//   ser_out, ser_valid                      : serial pattern bit stream
//   busy, done                              : run status
// Modport master is the sequencer side, slave is its environment.
// ---------------------------------------------------------------------------
interface pattern_sequencer_if;
    import pattern_seq_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_words;
    logic              loop;
    logic              stop;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              ser_out;
    logic              ser_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, num_words, loop, stop, mem_rdata,
        output mem_rd_en, mem_addr, ser_out, ser_valid, busy, done
    );

    modport slave (
        output start, base_addr, num_words, loop, stop, mem_rdata,
        input  mem_rd_en, mem_addr, ser_out, ser_valid, busy, done
    );

endinterface

// File: rtl/pattern_shifter.sv
// ---------------------------------------------------------------------------
// pattern_shifter
// Holds one pattern word and walks through its bits LSB first.
//   clock, reset : clock and asynchronous active-high reset
//   load         : capture load_data and restart at bit 0
//   advance      : step to the next bit
//   load_data    : word to capture
//   bit_idx      : index of the bit currently presented
//   bit_out      : the presented bit
// ---------------------------------------------------------------------------
module pattern_shifter
    import pattern_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] load_data,
    output logic [BIT_W-1:0]  bit_idx,
    output logic              bit_out
);

    logic [DATA_W-1:0] shift_reg;

    // A load wins over advance so the last bit of one word can hand straight
    // over to bit 0 of the next word without a gap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            bit_idx   <= '0;
        end else if (advance) begin
            bit_idx   <= bit_idx + 1'b1;
        end
    end

    assign bit_out = shift_reg[bit_idx];

endmodule

// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
// Reads words from a 16-entry pattern memory starting at base_addr and
// streams them out serially, LSB first, with the next word prefetched so
// consecutive words follow each other without a gap. Can repeat the pass
// indefinitely until stop is requested.
//   clock : single clock, all state updates on its rising edge
//   reset : asynchronous active-high reset, forces IDLE
//   bus   : pattern_sequencer_if.master (run control, memory read port,
//           serial output, busy/done status)
// ---------------------------------------------------------------------------
module pattern_sequencer
    import pattern_seq_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    pattern_sequencer_if.master bus
);

    seq_state_t        state;
    seq_state_t        state_next;

    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [CNT_W-1:0]  num_reg;
    logic [CNT_W-1:0]  word_cnt;
    logic              loop_reg;
    logic              stop_pending;

    logic [BIT_W-1:0]  bit_idx;
    logic              bit_out;
    logic              shift_load;
    logic              shift_advance;

    logic              at_bit6;
    logic              at_bit7;
    logic              pass_more;
    logic              word_follows;
    logic              next_word;

    logic              rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              ser_out_c;
    logic              ser_valid_c;
    logic              busy_c;
    logic              done_c;

    // word_cnt counts the words of this pass including the one being
    // shifted, so pass_more means another word remains in the pass.
    // word_follows decides the prefetch one bit early; a stop arriving in the
    // very last bit cycle still ends the run, discarding the prefetched word.
    assign at_bit6      = (state == SHIFT) && (bit_idx == BIT_W'(DATA_W - 2));
    assign at_bit7      = (state == SHIFT) && (bit_idx == BIT_W'(DATA_W - 1));
    assign pass_more    = (word_cnt < num_reg);
    assign word_follows = !stop_pending && (pass_more || loop_reg);
    assign next_word    = word_follows && !bus.stop;
    assign next_addr    = pass_more ? ADDR_W'(cur_addr + 1'b1) : base_reg;

    assign shift_load    = (state == LOAD) || (at_bit7 && next_word);
    assign shift_advance = (state == SHIFT);

    pattern_shifter u_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (shift_load),
        .advance   (shift_advance),
        .load_data (bus.mem_rdata),
        .bit_idx   (bit_idx),
        .bit_out   (bit_out)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An empty run skips straight to DONE without a read.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.num_words == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_next = LOAD;
            LOAD:  state_next = SHIFT;
            SHIFT: begin
                if (at_bit7) begin
                    state_next = next_word ? SHIFT : DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Run parameters are captured once at start; later changes on the inputs
    // (including a start while busy) do not disturb a run in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_reg <= '0;
            cur_addr <= '0;
            num_reg  <= '0;
            loop_reg <= 1'b0;
            word_cnt <= '0;
        end else if ((state == IDLE) && bus.start) begin
            base_reg <= bus.base_addr;
            cur_addr <= bus.base_addr;
            num_reg  <= bus.num_words;
            loop_reg <= bus.loop;
            word_cnt <= CNT_W'(1);
        end else if (at_bit7 && next_word) begin
            cur_addr <= next_addr;
            word_cnt <= pass_more ? CNT_W'(word_cnt + 1'b1) : CNT_W'(1);
        end
    end

    // Stop is remembered while busy and forgotten once the run has wound
    // down, so a stop in IDLE or DONE cannot leak into the next run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stop_pending <= 1'b0;
        end else if ((state == IDLE) || (state == DONE)) begin
            stop_pending <= 1'b0;
        end else if (bus.stop) begin
            stop_pending <= 1'b1;
        end
    end

    // Output decode. Outputs are driven only from state, so reset clears
    // them immediately; the address bus idles at zero when not reading.
    always_comb begin
        rd_en_c     = 1'b0;
        rd_addr_c   = '0;
        ser_out_c   = 1'b0;
        ser_valid_c = 1'b0;
        busy_c      = (state != IDLE);
        done_c      = (state == DONE);
        case (state)
            FETCH: begin
                rd_en_c   = 1'b1;
                rd_addr_c = cur_addr;
            end
            SHIFT: begin
                ser_valid_c = 1'b1;
                ser_out_c   = bit_out;
                if (at_bit6 && word_follows) begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = next_addr;
                end
            end
            default: begin
                rd_en_c = 1'b0;
            end
        endcase
    end

    assign bus.mem_rd_en = rd_en_c;
    assign bus.mem_addr  = rd_addr_c;
    assign bus.ser_out   = ser_out_c;
    assign bus.ser_valid = ser_valid_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;

endmodule

// File: tb/tb_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pattern_sequencer
// Drives runs of the pattern sequencer against a 16-word memory model and
// compares every cycle of the run with a cycle table built from the block's
// behaviour: word k of a run occupies serial cycles 3+8k..3+8k+7 after the
// accepting edge, word k reads address base+(k mod num), later words are
// requested two cycles before they are needed, and a stop ends the run after
// the word during which it arrived.
// ---------------------------------------------------------------------------
module tb_pattern_sequencer;
    import pattern_seq_pkg::*;

    localparam int MAXC = 256;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] mem [16];

    logic       e_valid [MAXC];
    logic       e_out   [MAXC];
    logic       e_rd    [MAXC];
    logic [3:0] e_addr  [MAXC];
    logic       e_busy  [MAXC];
    logic       e_done  [MAXC];

    pattern_sequencer_if bus ();

    pattern_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Memory answers one cycle after a read request; garbage otherwise so a
    // load at the wrong moment shows up in the serial stream.
    always @(posedge clock) begin
        if (bus.mem_rd_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
        end else begin
            bus.mem_rdata <= 8'($urandom);
        end
    end

    function automatic logic [15:0] all_outputs();
        return {7'd0, bus.busy, bus.done, bus.ser_valid, bus.ser_out,
                bus.mem_rd_en, bus.mem_addr};
    endfunction

    task automatic check_output(input string tag, input int cyc,
                                input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int c);
        check_output({tag, "/ser"}, c, {14'd0, bus.ser_valid, bus.ser_out},
                     {14'd0, e_valid[c], e_out[c]});
        check_output({tag, "/rd"}, c, {15'd0, bus.mem_rd_en}, {15'd0, e_rd[c]});
        if (e_rd[c]) begin
            check_output({tag, "/addr"}, c, {12'd0, bus.mem_addr}, {12'd0, e_addr[c]});
        end
        check_output({tag, "/sts"}, c, {14'd0, bus.busy, bus.done},
                     {14'd0, e_busy[c], e_done[c]});
    endtask

    // Builds the expected per-cycle table for one run. Cycle 1 is the cycle
    // right after the edge that accepts start.
    task automatic build_model(input int base, input int num, input bit lp,
                               input int stop_cyc, output int done_cyc);
        int natural_last;
        int stop_last;
        int last;
        int rc;
        logic [3:0] a;
        logic [7:0] w;
        for (int c = 0; c < MAXC; c++) begin
            e_valid[c] = 1'b0;
            e_out[c]   = 1'b0;
            e_rd[c]    = 1'b0;
            e_addr[c]  = 4'd0;
            e_busy[c]  = 1'b0;
            e_done[c]  = 1'b0;
        end
        if (num == 0) begin
            done_cyc = 1;
        end else begin
            natural_last = lp ? MAXC : num - 1;
            if (stop_cyc > 0) begin
                stop_last = (stop_cyc <= 2) ? 0 : (stop_cyc - 3) / 8;
            end else begin
                stop_last = MAXC;
            end
            last = (natural_last < stop_last) ? natural_last : stop_last;
            for (int k = 0; k <= last; k++) begin
                a = 4'((base + (k % num)) % 16);
                w = mem[a];
                for (int b = 0; b < 8; b++) begin
                    e_valid[3 + 8*k + b] = 1'b1;
                    e_out[3 + 8*k + b]   = w[b];
                end
                rc = (k == 0) ? 1 : 3 + 8*(k-1) + 6;
                e_rd[rc]   = 1'b1;
                e_addr[rc] = a;
            end
            // Stop in the last two bit cycles: the next word is still requested.
            if ((last < natural_last) && (stop_cyc >= 3 + 8*last + 6)) begin
                rc = 3 + 8*last + 6;
                e_rd[rc]   = 1'b1;
                e_addr[rc] = 4'((base + ((last + 1) % num)) % 16);
            end
            done_cyc = 3 + 8*(last + 1);
        end
        for (int c = 1; c <= done_cyc; c++) begin
            e_busy[c] = 1'b1;
        end
        e_done[done_cyc] = 1'b1;
    endtask

    // One complete run: an idle cycle with stop raised (must be ignored),
    // the start cycle, then every cycle of the run plus one idle cycle.
    task automatic apply_stimulus(input string tag, input int base, input int num,
                                  input bit lp, input int stop_cyc, input int glitch_cyc);
        int done_cyc;
        build_model(base, num, lp, stop_cyc, done_cyc);
        @(negedge clock);
        check_output({tag, "/idle"}, -1, all_outputs(), 16'd0);
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        @(negedge clock);
        check_output({tag, "/idle"}, 0, all_outputs(), 16'd0);
        bus.stop      = 1'b0;
        bus.start     = 1'b1;
        bus.base_addr = 4'(base);
        bus.num_words = 5'(num);
        bus.loop      = lp;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clock);
            check_cycle(tag, c);
            bus.start     = (c == glitch_cyc);
            bus.stop      = (c == stop_cyc);
            bus.base_addr = 4'($urandom);
            bus.num_words = 5'($urandom_range(0, 16));
            bus.loop      = 1'($urandom);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        int b;
        int n;
        int s;
        int g;
        bit lp;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.base_addr = 4'd0;
        bus.num_words = 5'd0;
        bus.loop      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = (i % 2 == 0) ? 8'hCC : 8'hAA;
        end

        #1;
        check_output("reset_async", 0, all_outputs(), 16'd0);
        repeat (2) @(negedge clock);
        check_output("reset_held", 0, all_outputs(), 16'd0);
        reset = 1'b0;

        // CC/AA stream, wrap at the top of memory, empty run.
        apply_stimulus("cc_aa", 0, 2, 1'b0, 0, 0);
        apply_stimulus("wrap", 15, 2, 1'b0, 0, 0);
        apply_stimulus("empty", 7, 0, 1'b0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'($urandom);
        end

        // Looping pass stopped mid-word, and stops on the last two bit cycles.
        apply_stimulus("loop_stop", 4, 3, 1'b1, 3 + 8*4 + 3, 0);
        apply_stimulus("stop_bit6", 9, 2, 1'b1, 3 + 8*2 + 6, 0);
        apply_stimulus("stop_bit7", 13, 4, 1'b1, 3 + 8*1 + 7, 0);
        apply_stimulus("stop_fetch", 3, 5, 1'b0, 1, 0);

        // Start pulsed while busy, then a full 16-word pass.
        apply_stimulus("busy_start", 2, 3, 1'b0, 0, 12);
        apply_stimulus("full16", 6, 16, 1'b0, 0, 0);

        // Reset in the middle of shifting, with a stop already pending.
        @(negedge clock);
        bus.start     = 1'b1;
        bus.base_addr = 4'd5;
        bus.num_words = 5'd3;
        bus.loop      = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        check_output("pre_reset_valid", 5, {15'd0, bus.ser_valid}, 16'd1);
        #2 reset = 1'b1;
        #1;
        check_output("reset_mid_shift", 5, all_outputs(), 16'd0);
        @(negedge clock);
        reset = 1'b0;
        apply_stimulus("after_reset", 11, 3, 1'b0, 0, 0);

        // Randomised runs.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] = 8'($urandom);
            end
            b  = $urandom_range(0, 15);
            n  = $urandom_range(0, 16);
            lp = 1'($urandom_range(0, 1));
            if (lp && (n != 0)) begin
                s = $urandom_range(1, 160);
            end else if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(1, 3 + 8*n + 1);
            end else begin
                s = 0;
            end
            g = ((n != 0) && ($urandom_range(0, 1) == 1)) ? $urandom_range(1, 10) : 0;
            apply_stimulus("random", b, n, lp, s, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, memory word-address width (16 words).
REQ-002 Parameter DATA_W, default 8, memory word width; the block SHALL support only 8.
REQ-003 Port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port start, input, 1, request to begin a run; sampled only in IDLE.
REQ-006 Port base_addr, input, ADDR_W, first word address; captured when start is accepted.
REQ-007 Port num_words, input, ADDR_W+1, words per pass, legal values 0..16; captured when start is accepted.
REQ-008 Port loop, input, 1, repeat the pass from base_addr indefinitely; captured when start is accepted.
REQ-009 Port stop, input, 1, graceful halt request; sampled only while busy.
REQ-010 Port mem_rd_en, output, 1, memory read strobe.
REQ-011 Port mem_addr, output, ADDR_W, memory read address.
REQ-012 Port mem_rdata, input, DATA_W, read data, valid exactly one cycle after mem_rd_en.
REQ-013 Port ser_out, output, 1, serial bit, LSB first.
REQ-014 Port ser_valid, output, 1, ser_out carries a pattern bit.
REQ-015 Port busy, output, 1, high in every state except IDLE.
REQ-016 Port done, output, 1, one-cycle pulse at run completion.

Function
REQ-017 States SHALL be IDLE, FETCH, LOAD, SHIFT and DONE.
REQ-018 IDLE with start=1 and num_words!=0 SHALL go to FETCH; with num_words=0 it SHALL go to DONE and issue no read.
REQ-019 FETCH SHALL last one cycle with mem_rd_en=1 and mem_addr=base_addr, then go to LOAD.
REQ-020 LOAD SHALL register mem_rdata into an 8-bit shift register, clear bit_idx, and go to SHIFT.
REQ-021 In SHIFT, ser_valid SHALL be 1 and ser_out SHALL equal shift-register bit bit_idx, with bit_idx counting 0..7.
REQ-022 The first ser_valid SHALL occur 3 cycles after the edge at which start is accepted.
REQ-023 While bit_idx=6, if another word follows, the block SHALL assert mem_rd_en with mem_addr = (current address + 1) mod 16.
REQ-024 While bit_idx=7, the block SHALL load mem_rdata, so that consecutive words stream with no ser_valid gap.
REQ-025 Word addresses SHALL wrap modulo 16; a run of 16 words therefore reads every location once.
REQ-026 A further word follows when fewer than num_words words have been sent in this pass, or when loop=1 and stop is not pending; a new pass restarts at base_addr.
REQ-027 After bit 7 of the last word, the block SHALL go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-029 A stop seen while busy SHALL set a pending flag; the current word SHALL finish, no further read SHALL be issued, and the block SHALL go to DONE.
REQ-030 start while busy SHALL be ignored; stop in IDLE SHALL be ignored.
REQ-031 If stop arrives in the bit_idx=6 cycle, the prefetch SHALL still occur and the fetched word SHALL be discarded.
REQ-032 In every non-SHIFT state, ser_valid and ser_out SHALL be 0.

Reset
REQ-033 Reset SHALL force IDLE immediately, including mid-run.
REQ-034 Reset SHALL drive mem_rd_en, mem_addr, ser_out, ser_valid, busy and done to 0, and clear all counters, the shift register and the stop-pending flag.

Structure
REQ-035 The state encoding, ADDR_W and DATA_W SHALL live in the shared package pattern_seq_pkg.
REQ-036 The shift register and bit counter SHALL form one sub-module, pattern_shifter (load, advance, bit_idx, bit_out).

Verification
REQ-037 Memory words alternate CC (even) and AA (odd); base 0, num 2 -> ser_out 0,0,1,1,0,0,1,1,0,1,0,1,0,1,0,1, then done 1 cycle after the last bit.
REQ-038 Wrap: base 15, num 2 -> reads at addresses 15 then 0; 16 contiguous ser_valid cycles.
REQ-039 num 0 -> done pulses 1 cycle after start is accepted; mem_rd_en never asserts.
REQ-040 loop=1, base 4, num 3 -> address sequence 4,5,6,4,5,...; stop mid-word -> that word completes, then done, with no further mem_rd_en.
REQ-041 Reset asserted mid-SHIFT -> all outputs 0 asynchronously; after release, a new start runs normally.
REQ-042 start pulsed while busy -> no effect on the address sequence or bit count.
